// File: rtl/ysyx_22050058_stage_buf.sv
// ysyx_22050058_stage_buf
// Valid/ready pipeline stage buffer carrying {pc, dnpc, inst, side} between
// two core pipeline stages. With SKID=1 it holds two entries (main = head,
// skid = overflow) and in_ready is a register, so out_ready never reaches
// in_ready combinationally. With SKID=0 it holds one entry and in_ready is
// !out_valid | out_ready. An empty buffer presents a NOP bubble payload.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_pc/in_dnpc/in_inst/in_side    upstream payload
//   out_valid/out_ready downstream handshake
//   out_pc/out_dnpc/out_inst/out_side head payload (bubble when empty)
//   flush               synchronous kill of held and incoming entries
//   occupancy           number of held entries (0..2)
//   stall_cnt           saturating count of cycles with out_valid & !out_ready

module ysyx_22050058_stage_buf #(
   parameter int          ADDR_W   = 64,
   parameter int          INST_W   = 32,
   parameter int          SIDE_W   = 1,
   parameter bit          SKID     = 1'b1,
   parameter logic [63:0] RST_PC   = 64'h8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [ADDR_W-1:0] in_dnpc,
   input  logic [INST_W-1:0] in_inst,
   input  logic [SIDE_W-1:0] in_side,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_dnpc,
   output logic [INST_W-1:0] out_inst,
   output logic [SIDE_W-1:0] out_side,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PW = 2*ADDR_W + INST_W + SIDE_W;
   localparam logic [PW-1:0] BUBBLE = {{ADDR_W{1'b0}}, ADDR_W'(RST_PC),
                                       INST_W'(NOP_INST), {SIDE_W{1'b0}}};

   logic          in_fire;
   logic          out_fire;
   logic [PW-1:0] in_data;
   logic [PW-1:0] head;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign in_data  = {in_pc, in_dnpc, in_inst, in_side};
   assign {out_pc, out_dnpc, out_inst, out_side} = head;

   generate
      if (SKID) begin : g_skid
         logic          main_valid;
         logic          skid_valid;
         logic          ready_q;
         logic [PW-1:0] main_q;
         logic [PW-1:0] skid_q;

         // The main register is reloaded with the bubble whenever it empties,
         // so the outputs come straight from flops in every state.
         // in_ready is low exactly while skid is full, hence in_fire can never
         // coincide with a skid->main move.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               main_valid <= 1'b0;
               main_q     <= BUBBLE;
               skid_valid <= 1'b0;
               skid_q     <= BUBBLE;
               ready_q    <= 1'b1;
            end else if (flush) begin
               main_valid <= 1'b0;
               main_q     <= BUBBLE;
               skid_valid <= 1'b0;
               ready_q    <= 1'b1;
            end else if (!main_valid || out_fire) begin
               ready_q <= 1'b1;
               if (skid_valid) begin
                  main_valid <= 1'b1;
                  main_q     <= skid_q;
                  skid_valid <= 1'b0;
               end else if (in_fire) begin
                  main_valid <= 1'b1;
                  main_q     <= in_data;
               end else begin
                  main_valid <= 1'b0;
                  main_q     <= BUBBLE;
               end
            end else if (in_fire) begin
               skid_valid <= 1'b1;
               skid_q     <= in_data;
               ready_q    <= 1'b0;
            end
         end

         assign in_ready  = ready_q;
         assign out_valid = main_valid;
         assign head      = main_q;
         // skid is only ever occupied behind a valid main entry
         assign occupancy = {skid_valid, main_valid & ~skid_valid};
      end else begin : g_single
         logic          valid_q;
         logic [PW-1:0] data_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               valid_q <= 1'b0;
               data_q  <= BUBBLE;
            end else if (flush) begin
               valid_q <= 1'b0;
               data_q  <= BUBBLE;
            end else if (in_fire) begin
               valid_q <= 1'b1;
               data_q  <= in_data;
            end else if (out_fire) begin
               valid_q <= 1'b0;
               data_q  <= BUBBLE;
            end
         end

         assign in_ready  = ~valid_q | out_ready;
         assign out_valid = valid_q;
         assign head      = data_q;
         assign occupancy = {1'b0, valid_q};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ysyx_22050058_stage_buf.sv
module tb_ysyx_22050058_stage_buf;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // SKID=1 instance (dut) and CNT_W=4 shadow (dut4) share stimulus
   logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [63:0] in_pc = '0, in_dnpc = '0;
   logic [31:0] in_inst = '0;
   logic [0:0]  in_side = '0;
   logic        in_ready, out_valid;
   logic [63:0] out_pc, out_dnpc;
   logic [31:0] out_inst;
   logic [0:0]  out_side;
   logic [1:0]  occupancy;
   logic [31:0] stall_cnt;

   logic        in_ready4, out_valid4;
   logic [63:0] out_pc4, out_dnpc4;
   logic [31:0] out_inst4;
   logic [0:0]  out_side4;
   logic [1:0]  occupancy4;
   logic [3:0]  stall_cnt4;

   // SKID=0 instance
   logic        in_valid0 = 1'b0, out_ready0 = 1'b0, flush0 = 1'b0;
   logic [63:0] in_pc0 = '0, in_dnpc0 = '0;
   logic [31:0] in_inst0 = '0;
   logic [0:0]  in_side0 = '0;
   logic        in_ready0, out_valid0;
   logic [63:0] out_pc0, out_dnpc0;
   logic [31:0] out_inst0;
   logic [0:0]  out_side0;
   logic [1:0]  occupancy0;
   logic [31:0] stall_cnt0;

   ysyx_22050058_stage_buf #(.SKID(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_dnpc(in_dnpc), .in_inst(in_inst), .in_side(in_side),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_dnpc(out_dnpc), .out_inst(out_inst), .out_side(out_side),
      .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt));

   ysyx_22050058_stage_buf #(.SKID(1'b1), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_pc(in_pc), .in_dnpc(in_dnpc), .in_inst(in_inst), .in_side(in_side),
      .out_valid(out_valid4), .out_ready(out_ready), .out_pc(out_pc4),
      .out_dnpc(out_dnpc4), .out_inst(out_inst4), .out_side(out_side4),
      .flush(flush), .occupancy(occupancy4), .stall_cnt(stall_cnt4));

   ysyx_22050058_stage_buf #(.SKID(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_pc(in_pc0), .in_dnpc(in_dnpc0), .in_inst(in_inst0), .in_side(in_side0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_pc(out_pc0),
      .out_dnpc(out_dnpc0), .out_inst(out_inst0), .out_side(out_side0),
      .flush(flush0), .occupancy(occupancy0), .stall_cnt(stall_cnt0));

   int tests = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // payload fields derived from pc so every field is checked per entry
   function automatic logic [63:0] dnpc_of(input logic [63:0] pc);
      return pc + 64'd4;
   endfunction
   function automatic logic [31:0] inst_of(input logic [63:0] pc);
      return pc[31:0] ^ 32'hA5A5_0000;
   endfunction
   function automatic logic [0:0] side_of(input logic [63:0] pc);
      return pc[2];
   endfunction

   task automatic drive(input logic v, input logic [63:0] pc, input logic rdy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_dnpc   = dnpc_of(pc);
      in_inst   = inst_of(pc);
      in_side   = side_of(pc);
      out_ready = rdy;
      flush     = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expected head payload: the entry itself, or the bubble when empty
   task automatic chk_head(input string tag, input logic ev, input logic [63:0] epc,
                           input logic [63:0] apc, input logic [63:0] adnpc,
                           input logic [31:0] ainst, input logic [0:0] aside);
      chk({tag, " out_pc"},   apc,   ev ? epc : 64'h0);
      chk({tag, " out_dnpc"}, adnpc, ev ? dnpc_of(epc) : 64'h8000_0000);
      chk({tag, " out_inst"}, {32'h0, ainst}, ev ? {32'h0, inst_of(epc)} : 64'h13);
      chk({tag, " out_side"}, {63'h0, aside}, ev ? {63'h0, side_of(epc)} : 64'h0);
   endtask

   typedef struct {
      logic        iv;
      logic [63:0] pc;
      logic        rdy;
      logic        fl;
      logic        ev;
      logic [63:0] epc;
      logic [1:0]  eocc;
      logic        eir;
      logic [31:0] estall;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic iv, input logic [63:0] pc, input logic rdy,
                               input logic fl, input logic ev, input logic [63:0] epc,
                               input logic [1:0] eocc, input logic eir, input logic [31:0] es);
      vec_t v;
      v.iv = iv; v.pc = pc; v.rdy = rdy; v.fl = fl;
      v.ev = ev; v.epc = epc; v.eocc = eocc; v.eir = eir; v.estall = es;
      return v;
   endfunction

   initial begin
      // streaming, one cycle latency
      vecs[0]  = mk(1, 64'h8000_0000, 1, 0, 1, 64'h8000_0000, 2'd1, 1, 0);
      vecs[1]  = mk(1, 64'h8000_0004, 1, 0, 1, 64'h8000_0004, 2'd1, 1, 0);
      vecs[2]  = mk(1, 64'h8000_0008, 1, 0, 1, 64'h8000_0008, 2'd1, 1, 0);
      vecs[3]  = mk(0, 64'h0,         1, 0, 0, 64'h0,         2'd0, 1, 0);
      // backpressure A,B,C; C held upstream while full
      vecs[4]  = mk(1, 64'h8000_0100, 0, 0, 1, 64'h8000_0100, 2'd1, 1, 0);
      vecs[5]  = mk(1, 64'h8000_0104, 0, 0, 1, 64'h8000_0100, 2'd2, 0, 1);
      vecs[6]  = mk(1, 64'h8000_0108, 0, 0, 1, 64'h8000_0100, 2'd2, 0, 2);
      vecs[7]  = mk(1, 64'h8000_0108, 1, 0, 1, 64'h8000_0104, 2'd1, 1, 2);
      vecs[8]  = mk(1, 64'h8000_0108, 1, 0, 1, 64'h8000_0108, 2'd1, 1, 2);
      vecs[9]  = mk(0, 64'h0,         1, 0, 0, 64'h0,         2'd0, 1, 2);
      // flush while full, D presented
      vecs[10] = mk(1, 64'h8000_0200, 0, 0, 1, 64'h8000_0200, 2'd1, 1, 2);
      vecs[11] = mk(1, 64'h8000_0204, 0, 0, 1, 64'h8000_0200, 2'd2, 0, 3);
      vecs[12] = mk(1, 64'h8000_0208, 0, 1, 0, 64'h0,         2'd0, 1, 4);
      vecs[13] = mk(0, 64'h0,         1, 0, 0, 64'h0,         2'd0, 1, 4);
      // flush with in_fire and out_fire in the same cycle: incoming discarded
      vecs[14] = mk(1, 64'h8000_0300, 0, 0, 1, 64'h8000_0300, 2'd1, 1, 4);
      vecs[15] = mk(1, 64'h8000_0304, 1, 1, 0, 64'h0,         2'd0, 1, 4);
      vecs[16] = mk(0, 64'h0,         1, 0, 0, 64'h0,         2'd0, 1, 4);

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst in_ready",  {63'h0, in_ready},  64'h1);
      chk("rst occupancy", {62'h0, occupancy}, 64'h0);
      chk_head("rst", 1'b0, 64'h0, out_pc, out_dnpc, out_inst, out_side);
      @(negedge clk);
      rst = 1'b1;
      #1;

      // ---- SKID=0: combinational in_ready and same-edge swap ----
      chk("s0 empty in_ready", {63'h0, in_ready0}, 64'h1);
      in_valid0 = 1'b1; in_pc0 = 64'h8000_1000; in_dnpc0 = 64'h8000_1004;
      in_inst0 = 32'h1111_0000; in_side0 = 1'b1; out_ready0 = 1'b0;
      step();
      chk("s0 load valid", {63'h0, out_valid0}, 64'h1);
      chk("s0 load pc",    out_pc0, 64'h8000_1000);
      chk("s0 load inst",  {32'h0, out_inst0}, 64'h1111_0000);
      chk("s0 load occ",   {62'h0, occupancy0}, 64'h1);
      in_pc0 = 64'h8000_2000; in_dnpc0 = 64'h8000_2004; in_inst0 = 32'h2222_0000;
      in_side0 = 1'b0;
      #1;
      chk("s0 stalled in_ready", {63'h0, in_ready0}, 64'h0);
      out_ready0 = 1'b1;
      #1;
      chk("s0 comb in_ready", {63'h0, in_ready0}, 64'h1);
      step();
      chk("s0 swap valid", {63'h0, out_valid0}, 64'h1);
      chk("s0 swap pc",    out_pc0, 64'h8000_2000);
      chk("s0 swap dnpc",  out_dnpc0, 64'h8000_2004);
      chk("s0 swap occ",   {62'h0, occupancy0}, 64'h1);
      in_valid0 = 1'b0;
      step();
      chk("s0 drain valid", {63'h0, out_valid0}, 64'h0);
      chk("s0 drain occ",   {62'h0, occupancy0}, 64'h0);
      chk("s0 drain pc",    out_pc0, 64'h0);
      chk("s0 drain dnpc",  out_dnpc0, 64'h8000_0000);
      chk("s0 drain inst",  {32'h0, out_inst0}, 64'h13);

      // ---- SKID=1 vector table ----
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].iv, vecs[i].pc, vecs[i].rdy, vecs[i].fl);
         step();
         chk($sformatf("v%0d out_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].ev});
         chk($sformatf("v%0d occupancy", i), {62'h0, occupancy}, {62'h0, vecs[i].eocc});
         chk($sformatf("v%0d in_ready", i),  {63'h0, in_ready},  {63'h0, vecs[i].eir});
         chk($sformatf("v%0d stall_cnt", i), {32'h0, stall_cnt}, {32'h0, vecs[i].estall});
         chk_head($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc,
                  out_pc, out_dnpc, out_inst, out_side);
      end

      // ---- asynchronous reset mid-stream at occupancy 2 ----
      drive(1'b1, 64'h8000_0400, 1'b0, 1'b0);
      step();
      step();
      chk("pre-rst occupancy", {62'h0, occupancy}, 64'h2);
      #3;
      rst = 1'b0;
      #1;
      chk("async rst out_valid", {63'h0, out_valid}, 64'h0);
      chk("async rst in_ready",  {63'h0, in_ready},  64'h1);
      chk("async rst occupancy", {62'h0, occupancy}, 64'h0);
      chk("async rst stall_cnt", {32'h0, stall_cnt}, 64'h0);
      chk_head("async rst", 1'b0, 64'h0, out_pc, out_dnpc, out_inst, out_side);
      @(negedge clk);
      rst = 1'b1;

      // ---- stall counter saturation (CNT_W=4) ----
      step();
      chk("sat load valid", {63'h0, out_valid4}, 64'h1);
      chk("sat start cnt",  {60'h0, stall_cnt4}, 64'h0);
      repeat (14) step();
      chk("sat cnt 14", {60'h0, stall_cnt4}, 64'd14);
      repeat (6) step();
      chk("sat cnt stops at 15", {60'h0, stall_cnt4}, 64'd15);
      chk("wide cnt 20",         {32'h0, stall_cnt},  64'd20);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ysyx_22050058_stage_buf.md
# ysyx_22050058_stage_buf

Parametrised valid/ready pipeline stage buffer carrying {pc, dnpc, inst, side} between two core pipeline stages (first instance: IF→ID), replacing the fixed stall/flush-vector register. A SKID mode adds a second entry so backpressure no longer needs a combinational ready path. An output bubble is a deterministic NOP payload. A saturating counter records downstream stall cycles.

## Interface
- ADDR_W, 64, width of pc/dnpc fields
- INST_W, 32, width of inst field
- SIDE_W, 1, width of opaque sideband field (must be ≥1)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- RST_PC, 64'h80000000, dnpc value presented during bubbles/reset (truncated to ADDR_W)
- NOP_INST, 32'h00000013, inst value presented during bubbles/reset
- CNT_W, 32, stall counter width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous assert, active-low (rst==0 resets), synchronous deassert supplied by system
- in_valid  in  1  upstream payload valid
- in_ready  out  1  buffer can accept this cycle
- in_pc / in_dnpc  in  ADDR_W  upstream pc / dynamic next pc
- in_inst  in  INST_W  upstream instruction
- in_side  in  SIDE_W  upstream sideband
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_pc / out_dnpc  out  ADDR_W  head pc / dnpc
- out_inst  out  INST_W  head instruction
- out_side  out  SIDE_W  head sideband
- flush  in  1  synchronous kill of all held and incoming entries
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Entries leave in arrival order.
- Bubble payload (out_valid=0): out_pc=0, out_dnpc=RST_PC, out_inst=NOP_INST, out_side=0. Outputs hold bubble payload whenever empty.
- Reset (rst=0, any time, mid-transfer included): out_valid=0, bubble payload, occupancy=0, in_ready=1, stall_cnt=0; all held entries lost.
- Priority each edge: reset > flush > normal transfer.
- Flush: next cycle occupancy=0, out_valid=0, bubble payload; data presented with in_fire in the flush cycle is discarded; a simultaneous out_fire still counts as consumed downstream. stall_cnt unaffected.
- SKID=1: entries main (head) and skid. in_ready is a register = !skid_valid.
  - Main empty or out_fire: main loads from skid if skid full (then skid takes in_fire data if any), else from input on in_fire, else becomes empty.
  - Main full, no out_fire, in_fire: data goes to skid; in_ready=0 from next cycle.
  - occupancy=2 is full: in_ready=0; returns to 1 the cycle after an out_fire.
- SKID=0: single entry; in_ready = !out_valid | out_ready (combinational). Load on in_fire, clear on out_fire without in_fire.
- stall_cnt: +1 each cycle out_valid & !out_ready; saturates at all-ones; cleared only by reset.

## Timing
- Latency: in_fire at edge N → out_valid=1 with that payload after edge N (visible cycle N+1) when empty; no same-cycle pass-through in either mode.
- Throughput: one entry per cycle sustained with out_ready=1, both modes.
- SKID=1: no combinational path from out_ready to in_ready; out_* come straight from main register.
- SKID=0: one combinational path out_ready→in_ready only.
- Simultaneous in_fire and out_fire at occupancy 1: occupancy stays 1, head replaced by new entry (or by skid entry when occupancy 2→2 with fresh in_fire impossible since in_ready=0).
- occupancy and in_ready updated at same edge as the transfer causing them.

## Test plan
- Reset: rst=0 asynchronously mid-stream with occupancy=2 → immediately out_valid=0, out_pc=0, out_dnpc=0x80000000, out_inst=0x00000013, in_ready=1, stall_cnt=0.
- Streaming: SKID=1, out_ready=1, push pc 0x80000000,0x80000004,0x80000008 back-to-back → same pcs appear on consecutive cycles, one cycle later, occupancy≤1.
- Backpressure: SKID=1, out_ready=0, push A,B,C → occupancy=2, in_ready=0 after B, C held upstream; out_ready=1 → A,B,C delivered in order, stall_cnt counts exactly the stalled cycles.
- Flush: occupancy=2 with in_fire of D and flush=1 same cycle → next cycle out_valid=0, bubble payload, occupancy=0; D never appears.
- SKID=0: out_ready=0 with one entry → in_ready=0 combinationally; out_ready=1 with in_valid=1 → entry swap same edge, occupancy stays 1.
- Counter saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15.
